rat_flags: RTL and testbench

Flag and interrupt-status unit for the RAT CPU, directly downstream of the ALU. Registers the ALU carry/zero outputs into the architectural C and Z flags, feeds C back to the ALU carry input, and holds shadow copies of C/Z for interrupt entry and return. Also owns the interrupt-enable flag I and a synchronized, edge-detected interrupt-pending latch. Its request output goes to the control unit.

---
 rtl/rat_flags.sv | 99 +++++++++
 tb/tb_rat_flags.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/rat_flags.sv
// Flag and interrupt-status unit for the RAT CPU: architectural C/Z, shadow
// copies for interrupt entry/return, interrupt enable and synchronized pending latch.
module rat_flags #(
   parameter int SYNC_STAGES = 2
) (
   input  logic CLK,
   input  logic RST,
   input  logic C_IN,
   input  logic Z_IN,
   input  logic FLG_C_LD,
   input  logic FLG_Z_LD,
   input  logic FLG_C_SET,
   input  logic FLG_C_CLR,
   input  logic FLG_LD_SEL,
   input  logic FLG_SHAD_LD,
   input  logic I_SET,
   input  logic I_CLR,
   input  logic INT_ACK,
   input  logic INTR,
   output logic C_FLAG,
   output logic Z_FLAG,
   output logic I_FLAG,
   output logic SHAD_C,
   output logic SHAD_Z,
   output logic INT_REQ
);

   logic                   c_q, c_d;
   logic                   z_q, z_d;
   logic                   i_q, i_d;
   logic                   shc_q, shc_d;
   logic                   shz_q, shz_d;
   logic                   pend_q, pend_d;
   logic [SYNC_STAGES-1:0] sync_q, sync_d;
   logic                   edge_q, edge_d;
   logic                   rise;

   assign rise = sync_q[SYNC_STAGES-1] & ~edge_q;

   always_comb begin
      c_d    = c_q;
      z_d    = z_q;
      i_d    = i_q;
      shc_d  = shc_q;
      shz_d  = shz_q;
      pend_d = pend_q;
      sync_d = {sync_q[SYNC_STAGES-2:0], INTR};
      edge_d = sync_q[SYNC_STAGES-1];

      if (FLG_C_CLR)     c_d = 1'b0;
      else if (FLG_C_SET) c_d = 1'b1;
      else if (FLG_C_LD)  c_d = FLG_LD_SEL ? shc_q : C_IN;

      if (FLG_Z_LD) z_d = FLG_LD_SEL ? shz_q : Z_IN;

      // Shadow takes the pre-edge flags, so a coincident load is not seen here.
      if (FLG_SHAD_LD || INT_ACK) begin
         shc_d = c_q;
         shz_d = z_q;
      end

      if (INT_ACK || I_CLR) i_d = 1'b0;
      else if (I_SET)       i_d = 1'b1;

      // A fresh edge wins over the acknowledge so the new event survives.
      if (rise)         pend_d = 1'b1;
      else if (INT_ACK) pend_d = 1'b0;
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         c_q    <= 1'b0;
         z_q    <= 1'b0;
         i_q    <= 1'b0;
         shc_q  <= 1'b0;
         shz_q  <= 1'b0;
         pend_q <= 1'b0;
         sync_q <= '0;
         edge_q <= 1'b0;
      end else begin
         c_q    <= c_d;
         z_q    <= z_d;
         i_q    <= i_d;
         shc_q  <= shc_d;
         shz_q  <= shz_d;
         pend_q <= pend_d;
         sync_q <= sync_d;
         edge_q <= edge_d;
      end
   end

   assign C_FLAG  = c_q;
   assign Z_FLAG  = z_q;
   assign I_FLAG  = i_q;
   assign SHAD_C  = shc_q;
   assign SHAD_Z  = shz_q;
   assign INT_REQ = pend_q & i_q;

endmodule

// File: tb/tb_rat_flags.sv
// Bench for rat_flags: directed scenarios with literal expectations plus a
// randomized run checked every cycle against a behavioural model.
module tb_rat_flags;
   localparam int SS = 2;

   logic CLK = 1'b0;
   logic RST = 1'b1;
   logic C_IN = 0, Z_IN = 0, FLG_C_LD = 0, FLG_Z_LD = 0, FLG_C_SET = 0, FLG_C_CLR = 0;
   logic FLG_LD_SEL = 0, FLG_SHAD_LD = 0, I_SET = 0, I_CLR = 0, INT_ACK = 0, INTR = 0;
   logic C_FLAG, Z_FLAG, I_FLAG, SHAD_C, SHAD_Z, INT_REQ;

   int errors = 0;
   int checks = 0;
   bit chk_en = 0;

   rat_flags #(.SYNC_STAGES(SS)) dut (
      .CLK(CLK), .RST(RST), .C_IN(C_IN), .Z_IN(Z_IN),
      .FLG_C_LD(FLG_C_LD), .FLG_Z_LD(FLG_Z_LD), .FLG_C_SET(FLG_C_SET),
      .FLG_C_CLR(FLG_C_CLR), .FLG_LD_SEL(FLG_LD_SEL), .FLG_SHAD_LD(FLG_SHAD_LD),
      .I_SET(I_SET), .I_CLR(I_CLR), .INT_ACK(INT_ACK), .INTR(INTR),
      .C_FLAG(C_FLAG), .Z_FLAG(Z_FLAG), .I_FLAG(I_FLAG),
      .SHAD_C(SHAD_C), .SHAD_Z(SHAD_Z), .INT_REQ(INT_REQ)
   );

   always #5 CLK = ~CLK;

   wire [5:0] outs = {C_FLAG, Z_FLAG, I_FLAG, SHAD_C, SHAD_Z, INT_REQ};

   task automatic chk(input string name, input logic [5:0] act, input logic [5:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got CZISsR=%b expected %b at %0t", name, act, exp, $time);
      end
   endtask

   // Behavioural model. INTR history: q[k] is the INTR value sampled k edges ago.
   bit m_c, m_z, m_i, m_sc, m_sz, m_p;
   bit q[$];

   function automatic bit samp(int k);
      return (k < q.size()) ? q[k] : 1'b0;
   endfunction

   always @(posedge CLK or posedge RST) begin
      if (RST) begin
         {m_c, m_z, m_i, m_sc, m_sz, m_p} = '0;
         q.delete();
      end else begin
         bit oc, oz, rise;
         oc = m_c;
         oz = m_z;
         q.push_front(INTR);
         if (q.size() > SS + 2) void'(q.pop_back());
         // Synchronized signal lags INTR by SS edges; pending sets on its 0->1 step.
         rise = samp(SS) && !samp(SS + 1);
         if (FLG_C_CLR)      m_c = 0;
         else if (FLG_C_SET) m_c = 1;
         else if (FLG_C_LD)  m_c = FLG_LD_SEL ? m_sc : C_IN;
         if (FLG_Z_LD)       m_z = FLG_LD_SEL ? m_sz : Z_IN;
         if (FLG_SHAD_LD || INT_ACK) begin
            m_sc = oc;
            m_sz = oz;
         end
         if (INT_ACK || I_CLR) m_i = 0;
         else if (I_SET)       m_i = 1;
         if (rise)         m_p = 1;
         else if (INT_ACK) m_p = 0;
      end
   end

   always @(negedge CLK) begin
      if (chk_en && !RST)
         chk("model", outs, {m_c, m_z, m_i, m_sc, m_sz, m_p & m_i});
   end

   task automatic step();
      @(posedge CLK);
      #1;
   endtask

   task automatic idle();
      {C_IN, Z_IN, FLG_C_LD, FLG_Z_LD, FLG_C_SET, FLG_C_CLR} = '0;
      {FLG_LD_SEL, FLG_SHAD_LD, I_SET, I_CLR, INT_ACK} = '0;
   endtask

   initial begin
      #2;
      chk("reset_state", outs, 6'b000000);
      step();
      RST = 0;
      chk_en = 1;

      // Async reset mid-operation
      FLG_C_SET = 1; FLG_Z_LD = 1; Z_IN = 1; I_SET = 1;
      step();
      chk("pre_reset", outs, 6'b111000);
      {C_IN, Z_IN, FLG_C_LD, FLG_Z_LD, FLG_C_SET, FLG_C_CLR} = '1;
      {FLG_LD_SEL, FLG_SHAD_LD, I_SET, I_CLR, INT_ACK, INTR} = '1;
      #1 RST = 1;
      #1 chk("async_reset", outs, 6'b000000);
      RST = 0;
      idle(); INTR = 0;
      step();
      chk("post_reset_hold", outs, 6'b000000);

      // Flag load and C priority
      C_IN = 1; Z_IN = 1; FLG_C_LD = 1; FLG_Z_LD = 1;
      step();
      chk("alu_load", outs, 6'b110000);
      idle(); FLG_C_LD = 1; FLG_C_SET = 1; FLG_C_CLR = 1;
      step();
      chk("clr_wins", outs, 6'b010000);

      // Shadow round trip
      idle(); FLG_C_SET = 1; FLG_Z_LD = 1; Z_IN = 0;
      step();
      chk("c1_z0", outs, 6'b100000);
      idle(); FLG_SHAD_LD = 1; FLG_C_LD = 1; C_IN = 0;
      step();
      chk("shadow_old_vals", outs, 6'b000100);
      idle(); FLG_LD_SEL = 1; FLG_C_LD = 1; FLG_Z_LD = 1; C_IN = 0; Z_IN = 1;
      step();
      chk("shadow_restore", outs, 6'b100100);

      // Interrupt latency
      idle(); I_SET = 1;
      step();
      chk("i_set", outs, 6'b101100);
      idle(); INTR = 1;
      step();
      chk("lat_n", outs, 6'b101100);
      step();
      chk("lat_n1", outs, 6'b101100);
      step();
      chk("lat_n2", outs, 6'b101101);
      INT_ACK = 1;
      step();
      chk("ack", outs, 6'b100100);
      INT_ACK = 0;
      repeat (3) begin
         step();
         chk("ack_level_held", outs, 6'b100100);
      end

      // Masked pending
      INTR = 0;
      repeat (3) step();
      INTR = 1;
      repeat (3) begin
         step();
         chk("masked", outs, 6'b100100);
      end
      INTR = 0;
      repeat (3) begin
         step();
         chk("masked_hold", outs, 6'b100100);
      end
      I_SET = 1;
      step();
      chk("unmask", outs, 6'b101101);

      // Rising edge coincident with INT_ACK keeps pending
      I_SET = 0; INTR = 1;
      step();
      step();
      INT_ACK = 1;
      step();
      chk("edge_with_ack", outs, 6'b100100);
      INT_ACK = 0; I_SET = 1;
      step();
      chk("pending_kept", outs, 6'b101101);
      INT_ACK = 1; I_SET = 1;
      step();
      chk("ack_beats_iset", outs, 6'b100100);
      INT_ACK = 0; I_SET = 1;
      step();
      chk("pending_cleared", outs, 6'b101100);

      // Randomized run
      idle(); INTR = 0;
      repeat (3000) begin
         step();
         C_IN        = $urandom_range(1);
         Z_IN        = $urandom_range(1);
         FLG_C_LD    = $urandom_range(99) < 30;
         FLG_Z_LD    = $urandom_range(99) < 30;
         FLG_C_SET   = $urandom_range(99) < 10;
         FLG_C_CLR   = $urandom_range(99) < 10;
         FLG_LD_SEL  = $urandom_range(99) < 30;
         FLG_SHAD_LD = $urandom_range(99) < 10;
         I_SET       = $urandom_range(99) < 15;
         I_CLR       = $urandom_range(99) < 8;
         INT_ACK     = $urandom_range(99) < 8;
         if ($urandom_range(99) < 15) INTR = ~INTR;
         if ($urandom_range(199) == 0) begin
            #1 RST = 1;
            #1 chk("rand_async_reset", outs, 6'b000000);
            RST = 0;
         end
      end

      idle();
      step();
      chk_en = 0;
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
